instr_loader: RTL

Writes a program image into the instruction memory from a byte stream, so a program can be loaded at run time instead of only through the simulation-time hex preload. Bytes arrive over a valid/ready byte interface and are packed little-endian into 32-bit words (byte 0 = bits [7:0]). Each word is written through a single-cycle write strobe to consecutive word addresses starting at 0. The CPU is held in reset while a load is in progress.

---
 rtl/instr_loader_if.sv | 14 +
 rtl/instr_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of instr_loader.
interface instr_loader_if #(parameter int ADDR_WIDTH = 8);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  modport master (output byte_valid, byte_data,
                  input  byte_ready, mem_we, mem_waddr, mem_wdata);
  modport slave  (input  byte_valid, byte_data,
                  output byte_ready, mem_we, mem_waddr, mem_wdata);
endinterface

// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory.
// Optional trailing XOR checksum byte is enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  instr_loader_if.slave bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE
  } state_e;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CHK;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic accept, in_range, last_word;

  assign accept    = bus.byte_valid && bus.byte_ready;
  // Words past the end of memory are swallowed, so the address never wraps.
  assign in_range  = {1'b0, wcnt_q} < DEPTH;
  assign last_word = (wcnt_q + 16'd1) == len_q;

  assign bus.byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CHK);
  assign bus.mem_we     = (state_q == S_WRITE) && in_range;
  assign bus.mem_waddr  = wcnt_q[ADDR_WIDTH-1:0];
  assign bus.mem_wdata  = word_q;
  assign cpu_hold       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign load_done      = (state_q == S_DONE);
  assign load_err       = err_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    lane_d  = lane_q;
    word_d  = word_q;
    err_d   = err_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          wcnt_d  = '0;
          lane_d  = '0;
          err_d   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.byte_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.byte_data;
          state_d     = ({bus.byte_data, len_q[7:0]} != 16'd0) ? S_DATA : S_END;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[{lane_q, 3'b000} +: 8] = bus.byte_data;
          lane_d = lane_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ bus.byte_data;
`endif
          if (lane_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!in_range) err_d = 1'b1;
        wcnt_d  = wcnt_q + 16'd1;
        state_d = last_word ? S_END : S_DATA;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (bus.byte_data != xor_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      err_q   <= err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end
endmodule
